// File: rtl/card_shoe_if.sv
// Draw interface between the game control (master) and the card source (slave).
interface card_shoe_if;
    logic       req;
    logic       shuffle;
    logic       card_valid;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       empty;
    logic       busy;

    modport master (
        output req,
        output shuffle,
        input  card_valid,
        input  card_value,
        input  cards_left,
        input  empty,
        input  busy
    );

    modport slave (
        input  req,
        input  shuffle,
        output card_valid,
        output card_value,
        output cards_left,
        output empty,
        output busy
    );
endinterface

// File: rtl/card_shoe.sv
// Single-deck card source: deals each of 52 cards once, starting the search at an LFSR position.
// Define CARD_SHOE_FACE_CLAMP_EN to report ranks 11..13 as 10.
module card_shoe #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input logic         clock,
    input logic         reset,
    card_shoe_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StSearch, StDeliver, StWaitRelease} state_e;

    state_e      state_q, state_d;
    logic [51:0] used_q, used_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  cards_left_q, cards_left_d;
    logic [3:0]  card_q, card_d;
    logic [5:0]  start_idx;
    logic [5:0]  rank_raw;
    logic [3:0]  rank;

    // Fibonacci taps 16,14,13,11; a nonzero seed never reaches zero.
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign start_idx = (lfsr_q[5:0] >= 6'd52) ? lfsr_q[5:0] - 6'd52 : lfsr_q[5:0];

    always_comb begin
        rank_raw = 6'd0;
        if (ptr_q < 6'd13) begin
            rank_raw = ptr_q + 6'd1;
        end else if (ptr_q < 6'd26) begin
            rank_raw = ptr_q - 6'd12;
        end else if (ptr_q < 6'd39) begin
            rank_raw = ptr_q - 6'd25;
        end else begin
            rank_raw = ptr_q - 6'd38;
        end
        rank = rank_raw[3:0];
`ifdef CARD_SHOE_FACE_CLAMP_EN
        if (rank > 4'd10) begin
            rank = 4'd10;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        used_d       = used_q;
        ptr_d        = ptr_q;
        cards_left_d = cards_left_q;
        card_d       = card_q;
        if (bus.shuffle) begin
            used_d       = '0;
            cards_left_d = 6'd52;
            card_d       = 4'd0;
            state_d      = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req && (cards_left_q != 6'd0)) begin
                        ptr_d   = start_idx;
                        state_d = StSearch;
                    end
                end
                StSearch: begin
                    if (!used_q[ptr_q]) begin
                        used_d[ptr_q] = 1'b1;
                        card_d        = rank;
                        if (cards_left_q != 6'd0) begin
                            cards_left_d = cards_left_q - 6'd1;
                        end
                        state_d = StDeliver;
                    end else begin
                        ptr_d = (ptr_q == 6'd51) ? 6'd0 : ptr_q + 6'd1;
                    end
                end
                StDeliver: begin
                    state_d = StWaitRelease;
                end
                StWaitRelease: begin
                    if (!bus.req) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            used_q       <= '0;
            lfsr_q       <= SEED;
            ptr_q        <= 6'd0;
            cards_left_q <= 6'd52;
            card_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            used_q       <= used_d;
            lfsr_q       <= lfsr_d;
            ptr_q        <= ptr_d;
            cards_left_q <= cards_left_d;
            card_q       <= card_d;
        end
    end

    // A shuffle or reset arriving in the delivery cycle suppresses the strobe.
    assign bus.card_valid = (state_q == StDeliver) && !bus.shuffle && !reset;
    assign bus.card_value = card_q;
    assign bus.cards_left = cards_left_q;
    assign bus.empty      = (cards_left_q == 6'd0);
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: latency, full-deck rank census, empty shoe, held req, shuffle, reset.
module tb_card_shoe;

    logic clock;
    logic reset;
    card_shoe_if bus ();

    card_shoe #(.SEED(16'hACE1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int vcount = 0;
    int rc[16];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.card_valid === 1'b1) vcount++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise req until a strobe is seen (bounded), then release and let the FSM return to idle.
    task automatic deal(output int val, output int lat, output int emp, output int cl);
        bus.req = 1'b1;
        lat = -1;
        val = 0;
        emp = 0;
        cl  = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (bus.card_valid === 1'b1) begin
                lat = i;
                val = int'(bus.card_value);
                emp = int'(bus.empty);
                cl  = int'(bus.cards_left);
                break;
            end
        end
        bus.req = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int val, lat, emp, cl, v0, missing, bad_range, exp_cnt;
        bus.req     = 1'b0;
        bus.shuffle = 1'b0;
        reset       = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        check("reset_card_value", int'(bus.card_value), 0);
        check("reset_cards_left", int'(bus.cards_left), 52);
        check("reset_empty", int'(bus.empty), 0);
        check("reset_card_valid", int'(bus.card_valid), 0);
        check("reset_busy", int'(bus.busy), 0);

        for (int r = 0; r < 16; r++) rc[r] = 0;
        v0 = vcount;
        deal(val, lat, emp, cl);
        check("first_latency", lat, 2);
        check("first_in_range", int'(val >= 1 && val <= 13), 1);
        check("first_cards_left", cl, 51);
        check("first_strobe_count", vcount - v0, 1);
        check("first_value_held", int'(bus.card_value), val);
        rc[val]++;

        missing = 0;
        bad_range = 0;
        for (int n = 2; n <= 52; n++) begin
            deal(val, lat, emp, cl);
            if (lat < 0) missing++;
            if (val < 1 || val > 13) bad_range++;
            if (cl != 52 - n) bad_range++;
            rc[val]++;
            if (n == 51) check("empty_before_last", emp, 0);
        end
        check("deck_missing_cards", missing, 0);
        check("deck_bad_value_or_count", bad_range, 0);
        check("empty_with_52nd_strobe", emp, 1);
        check("deck_strobe_count", vcount - v0, 52);
        for (int r = 1; r <= 13; r++) begin
`ifdef CARD_SHOE_FACE_CLAMP_EN
            exp_cnt = (r < 10) ? 4 : ((r == 10) ? 16 : 0);
`else
            exp_cnt = 4;
`endif
            check($sformatf("rank_count_%0d", r), rc[r], exp_cnt);
        end

        v0 = vcount;
        bus.req = 1'b1;
        repeat (60) tick();
        check("empty_req_no_strobe", vcount - v0, 0);
        check("empty_req_cards_left", int'(bus.cards_left), 0);
        check("empty_req_not_busy", int'(bus.busy), 0);
        bus.req = 1'b0;
        tick();

        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        check("shuffle_cards_left", int'(bus.cards_left), 52);
        check("shuffle_empty", int'(bus.empty), 0);
        check("shuffle_card_value", int'(bus.card_value), 0);

        v0 = vcount;
        bus.req = 1'b1;
        repeat (100) tick();
        check("held_req_one_strobe", vcount - v0, 1);
        check("held_req_busy", int'(bus.busy), 1);
        bus.req = 1'b0;
        repeat (3) tick();
        check("held_release_idle", int'(bus.busy), 0);
        deal(val, lat, emp, cl);
        check("held_second_card", int'(lat > 0), 1);
        check("held_second_cards_left", cl, 50);

        missing = 0;
        for (int n = 0; n < 49; n++) begin
            deal(val, lat, emp, cl);
            if (lat < 0) missing++;
        end
        check("pre_abort_missing", missing, 0);
        check("pre_abort_cards_left", int'(bus.cards_left), 1);

        v0 = vcount;
        bus.req = 1'b1;
        tick();
        check("abort_in_search", int'(bus.busy), 1);
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        bus.req = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_cards_left", int'(bus.cards_left), 52);
        check("abort_card_value", int'(bus.card_value), 0);
        repeat (5) tick();
        check("abort_no_strobe", vcount - v0, 0);
        deal(val, lat, emp, cl);
        check("post_abort_latency", lat, 2);
        check("post_abort_cards_left", cl, 51);
        check("post_abort_in_range", int'(val >= 1 && val <= 13), 1);

        v0 = vcount;
        bus.req = 1'b1;
        tick();
        reset = 1'b1;
        bus.req = 1'b0;
        tick();
        reset = 1'b0;
        check("midsearch_reset_cards_left", int'(bus.cards_left), 52);
        check("midsearch_reset_busy", int'(bus.busy), 0);
        check("midsearch_reset_card_value", int'(bus.card_value), 0);
        repeat (3) tick();
        check("midsearch_reset_no_strobe", vcount - v0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
